hilo_muldiv: RTL

HILO_MULDIV -- requirements
Module: hilo_muldiv

---
 rtl/hilo_pkg.sv | 28 ++
 rtl/div_seq32.sv | 69 ++++++
 rtl/hilo_muldiv.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM states,
// divider iteration count and a magnitude helper.
package hilo_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MADD  = 3'b100,
        OP_MSUB  = 3'b101,
        OP_MTHI  = 3'b110,
        OP_MTLO  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_DIV_RUN = 2'b01,
        ST_DIV_FIX = 2'b10
    } state_e;

    localparam int DIV_CYCLES = 32;

    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/div_seq32.sv
// Iterative 32-bit restoring divider: one shift-subtract step per enabled cycle,
// with sign correction applied combinationally to the final quotient/remainder.
module div_seq32
    import hilo_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        last,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    localparam logic [5:0] CNT_LAST = 6'(DIV_CYCLES - 1);

    logic [31:0] quo_r;
    logic [31:0] rem_r;
    logic [31:0] dvsr_r;
    logic [5:0]  cnt_r;
    logic        neg_q_r;
    logic        neg_r_r;
    logic [32:0] shift_s;
    logic        ge_s;
    logic [31:0] diff_s;

    // Trial subtraction for the current step and sign-corrected results.
    always_comb begin
        shift_s   = {rem_r, quo_r[31]};
        ge_s      = (shift_s >= {1'b0, dvsr_r});
        diff_s    = shift_s[31:0] - dvsr_r;
        last      = (cnt_r == CNT_LAST);
        quotient  = neg_q_r ? (32'd0 - quo_r) : quo_r;
        remainder = neg_r_r ? (32'd0 - rem_r) : rem_r;
    end

    // Operand latch on load, then one restoring step per enabled cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quo_r   <= 32'd0;
            rem_r   <= 32'd0;
            dvsr_r  <= 32'd0;
            cnt_r   <= 6'd0;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
        end else if (load) begin
            quo_r   <= mag32(dividend, is_signed);
            rem_r   <= 32'd0;
            dvsr_r  <= mag32(divisor, is_signed);
            cnt_r   <= 6'd0;
            // A zero divisor keeps the all-ones quotient un-negated.
            neg_q_r <= is_signed && (dividend[31] ^ divisor[31]) && (divisor != 32'd0);
            neg_r_r <= is_signed && dividend[31];
        end else if (step) begin
            if (ge_s) begin
                rem_r <= diff_s;
                quo_r <= {quo_r[30:0], 1'b1};
            end else begin
                rem_r <= shift_s[31:0];
                quo_r <= {quo_r[30:0], 1'b0};
            end
            cnt_r <= cnt_r + 6'd1;
        end
    end

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO register unit: single-cycle multiply/accumulate/move, multi-cycle
// divide through div_seq32, with flush and busy/done handshake.
module hilo_muldiv
    import hilo_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic [31:0] hiout,
    output logic [31:0] loout,
    output logic        busy,
    output logic        done
);

    state_e      state_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic        busy_r;
    logic        done_r;

    op_e         op_s;
    logic [63:0] a_sx_s;
    logic [63:0] b_sx_s;
    logic [63:0] prod_signed_s;
    logic [63:0] prod_unsigned_s;
    logic        div_load_s;
    logic        div_step_s;
    logic        div_signed_s;
    logic        div_last_s;
    logic [31:0] div_quot_s;
    logic [31:0] div_rem_s;

    // Products and divider control decode.
    always_comb begin
        op_s            = op_e'(op);
        a_sx_s          = {{32{a[31]}}, a};
        b_sx_s          = {{32{b[31]}}, b};
        prod_signed_s   = a_sx_s * b_sx_s;
        prod_unsigned_s = {32'd0, a} * {32'd0, b};
        div_signed_s    = (op_s == OP_DIV);
        if ((state_r == ST_IDLE) && start && !flush &&
            ((op_s == OP_DIV) || (op_s == OP_DIVU))) begin
            div_load_s = 1'b1;
        end else begin
            div_load_s = 1'b0;
        end
        if ((state_r == ST_DIV_RUN) && !flush) begin
            div_step_s = 1'b1;
        end else begin
            div_step_s = 1'b0;
        end
    end

    div_seq32 u_div (
        .clk       (clk),
        .rst       (rst),
        .load      (div_load_s),
        .step      (div_step_s),
        .is_signed (div_signed_s),
        .dividend  (a),
        .divisor   (b),
        .last      (div_last_s),
        .quotient  (div_quot_s),
        .remainder (div_rem_s)
    );

    // Control FSM and HI/LO register updates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start && !flush) begin
                        case (op_s)
                            OP_MULT: begin
                                {hi_r, lo_r} <= prod_signed_s;
                                done_r       <= 1'b1;
                            end
                            OP_MULTU: begin
                                {hi_r, lo_r} <= prod_unsigned_s;
                                done_r       <= 1'b1;
                            end
                            OP_MADD: begin
                                {hi_r, lo_r} <= {hi_r, lo_r} + prod_signed_s;
                                done_r       <= 1'b1;
                            end
                            OP_MSUB: begin
                                {hi_r, lo_r} <= {hi_r, lo_r} - prod_signed_s;
                                done_r       <= 1'b1;
                            end
                            OP_MTHI: begin
                                hi_r   <= a;
                                done_r <= 1'b1;
                            end
                            OP_MTLO: begin
                                lo_r   <= a;
                                done_r <= 1'b1;
                            end
                            OP_DIV, OP_DIVU: begin
                                state_r <= ST_DIV_RUN;
                                busy_r  <= 1'b1;
                            end
                            default: begin
                                state_r <= ST_IDLE;
                            end
                        endcase
                    end
                end
                ST_DIV_RUN: begin
                    if (flush) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else if (div_last_s) begin
                        state_r <= ST_DIV_FIX;
                    end
                end
                ST_DIV_FIX: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    if (!flush) begin
                        hi_r   <= div_rem_s;
                        lo_r   <= div_quot_s;
                        done_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign hiout = hi_r;
    assign loout = lo_r;
    assign busy  = busy_r;
    assign done  = done_r;

endmodule
